// File: rtl/core_pkg.sv
// Shared types and operation predicates for the iterative multiply/divide unit.
package core_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    function automatic logic is_div(input muldiv_op_e op);
        return op[2];
    endfunction

    function automatic logic is_rem(input muldiv_op_e op);
        return (op == REM) || (op == REMU);
    endfunction

    function automatic logic is_signed_a(input muldiv_op_e op);
        return (op == MUL) || (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_signed_b(input muldiv_op_e op);
        return (op == MUL) || (op == MULH) || (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_high(input muldiv_op_e op);
        return (op == MULH) || (op == MULHSU) || (op == MULHU);
    endfunction

endpackage

// File: rtl/core_muldiv_dp.sv
// Shared shift/add (multiply) and restoring shift/subtract (divide) datapath, one bit per step.
module core_muldiv_dp #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            div_mode,
    input  logic [XLEN-1:0] load_opnd,
    input  logic [XLEN-1:0] load_lo,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);

    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] opnd;
    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   trial;
    logic            trial_ge;
    logic [XLEN-1:0] trial_diff;

    // hi:lo is the running product (mul) or remainder:quotient-shifter (div)
    always_comb begin
        add_sum    = {1'b0, hi} + {1'b0, opnd};
        trial      = {hi, lo[XLEN-1]};
        trial_ge   = (trial >= {1'b0, opnd});
        trial_diff = XLEN'(trial - {1'b0, opnd});
        hi_nxt     = hi;
        lo_nxt     = lo;
        if (div_mode) begin
            if (trial_ge) begin
                hi_nxt = trial_diff;
                lo_nxt = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt = trial[XLEN-1:0];
                lo_nxt = {lo[XLEN-2:0], 1'b0};
            end
        end else if (lo[0]) begin
            hi_nxt = add_sum[XLEN:1];
            lo_nxt = {add_sum[0], lo[XLEN-1:1]};
        end else begin
            hi_nxt = {1'b0, hi[XLEN-1:1]};
            lo_nxt = {hi[0], lo[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi   <= '0;
            lo   <= '0;
            opnd <= '0;
        end else if (load) begin
            hi   <= '0;
            lo   <= load_lo;
            opnd <= load_opnd;
        end else if (step) begin
            hi   <= hi_nxt;
            lo   <= lo_nxt;
        end
    end

endmodule

// File: rtl/core_muldiv.sv
// Iterative RISC-V style multiply/divide unit with valid/ready handshake and kill.
// Define CORE_MULDIV_FAST_MUL_EN for single-cycle combinational multiplies.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// CALC  | one datapath step per cycle, XLEN cycles
// DONE  | result held, out_valid high until out_ready
module core_muldiv
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  muldiv_op_e      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e   state;
    logic [CNT_W-1:0] cnt;
    muldiv_op_e      op_q;
    logic            neg_q;

    logic            accept;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            neg_in;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] hi_nxt;
    logic [XLEN-1:0] lo_nxt;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] fix_res;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready & ~kill;

    always_comb begin
        sign_a   = is_signed_a(op) & src_a[XLEN-1];
        sign_b   = is_signed_b(op) & src_b[XLEN-1];
        mag_a    = sign_a ? -src_a : src_a;
        mag_b    = sign_b ? -src_b : src_b;
        // remainder follows the dividend; quotient and product follow sign_a ^ sign_b
        neg_in   = is_rem(op) ? sign_a : (sign_a ^ sign_b);
        div_zero = is_div(op) && (src_b == '0);
        div_ovf  = is_div(op) && is_signed_a(op) && (src_a == MOST_NEG) && (src_b == '1);
    end

    core_muldiv_dp #(.XLEN(XLEN)) u_dp (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .step      ((state == CALC) && !kill),
        .div_mode  (is_div(op_q)),
        .load_opnd (is_div(op) ? mag_b : mag_a),
        .load_lo   (is_div(op) ? mag_a : mag_b),
        .hi_nxt    (hi_nxt),
        .lo_nxt    (lo_nxt)
    );

    // Sign fix-up applied to the final step's outputs so DONE carries the answer
    always_comb begin
        prod    = neg_q ? -{hi_nxt, lo_nxt} : {hi_nxt, lo_nxt};
        fix_res = '0;
        if (!is_div(op_q))
            fix_res = is_high(op_q) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        else if (is_rem(op_q))
            fix_res = neg_q ? -hi_nxt : hi_nxt;
        else
            fix_res = neg_q ? -lo_nxt : lo_nxt;
    end

`ifdef CORE_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] ext_a;
    logic [2*XLEN-1:0] ext_b;
    logic [2*XLEN-1:0] fast_prod;
    logic [XLEN-1:0]   fast_res;

    always_comb begin
        ext_a     = {{XLEN{is_signed_a(op) & src_a[XLEN-1]}}, src_a};
        ext_b     = {{XLEN{is_signed_b(op) & src_b[XLEN-1]}}, src_b};
        fast_prod = ext_a * ext_b;
        fast_res  = is_high(op) ? fast_prod[2*XLEN-1:XLEN] : fast_prod[XLEN-1:0];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= MUL;
            neg_q  <= 1'b0;
            result <= '0;
        end else if (kill) begin
            state  <= IDLE;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q  <= op;
                    neg_q <= neg_in;
                    cnt   <= '0;
                    if (div_zero) begin
                        result <= is_rem(op) ? src_a : '1;
                        state  <= DONE;
                    end else if (div_ovf) begin
                        result <= is_rem(op) ? '0 : src_a;
                        state  <= DONE;
`ifdef CORE_MULDIV_FAST_MUL_EN
                    end else if (!is_div(op)) begin
                        result <= fast_res;
                        state  <= DONE;
`endif
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: if (cnt == LAST) begin
                    cnt    <= '0;
                    result <= fix_res;
                    state  <= DONE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_muldiv.sv
// Self-checking bench for core_muldiv: directed corner cases plus random ops against a 64-bit arithmetic model.
module tb_core_muldiv;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    muldiv_op_e  op = MUL;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        kill = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;

    int n_vec = 0;
    int n_err = 0;

    core_muldiv #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input muldiv_op_e o, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (o)
            MUL:    begin p = sa * sb;              return p[31:0];  end
            MULH:   begin p = sa * sb;              return p[63:32]; end
            MULHSU: begin p = sa * longint'(ub);    return p[63:32]; end
            MULHU:  begin p = ua * ub;              return p[63:32]; end
            DIV:    begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            REM:    begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default:begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic int ref_latency(input muldiv_op_e o, input logic [31:0] a, input logic [31:0] b);
        if (o inside {DIV, DIVU, REM, REMU}) begin
            if (b == 0) return 1;
            if ((o == DIV || o == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
`ifdef CORE_MULDIV_FAST_MUL_EN
        return 1;
`else
        return 33;
`endif
    endfunction

    task automatic do_op(input muldiv_op_e o, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] exp;
        int          lat;
        exp = ref_model(o, a, b);
        @(negedge clk);
        op = o; src_a = a; src_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        src_a = $urandom; src_b = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("lat %s", o.name()), 32'(lat), 32'(ref_latency(o, a, b)));
        check($sformatf("res %s %h %h", o.name(), a, b), result, exp);
        if (!out_valid) begin
            kill = 1'b1; @(posedge clk); #1; kill = 1'b0;
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold out_valid", {31'b0, out_valid}, 32'd1);
            check("hold result", result, exp);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        check("after take out_valid", {31'b0, out_valid}, 32'd0);
        check("after take in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int seen;
        #1;
        check("rst out_valid", {31'b0, out_valid}, 32'd0);
        check("rst result", result, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst in_ready", {31'b0, in_ready}, 32'd1);

        do_op(MUL,    32'd7,         32'hFFFF_FFFD, 0);
        do_op(MULH,   32'h8000_0000, 32'h8000_0000, 0);
        do_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(DIVU,   32'h1234,      32'h0,         0);
        do_op(REMU,   32'h1234,      32'h0,         0);
        do_op(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(REM,    32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(DIV,    -32'd7,        32'd2,         0);
        do_op(REM,    -32'd7,        32'd2,         5);

        // kill ten cycles into a divide
        @(negedge clk);
        op = DIV; src_a = 32'd1000; src_b = 32'd7; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(posedge clk); #1; kill = 1'b0;
        check("kill in_ready", {31'b0, in_ready}, 32'd1);
        check("kill out_valid", {31'b0, out_valid}, 32'd0);
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
        check("kill spurious out_valid", 32'(seen), 32'd0);
        do_op(MUL, 32'd3, 32'd4, 0);

        // reset in the middle of a multiply
        @(negedge clk);
        op = MULHU; src_a = 32'hDEAD_BEEF; src_b = 32'h1234_5678; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1; #1;
        check("midrst out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst in_ready", {31'b0, in_ready}, 32'd1);
        check("midrst result", result, 32'd0);
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
        check("midrst spurious out_valid", 32'(seen), 32'd0);

        for (int i = 0; i < 200; i++) begin
            do_op(muldiv_op_e'($urandom_range(0, 7)), rand_operand(), rand_operand(), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
